adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one multi-precision adder/subtractor (start/subtract/in_a/in_b -> result/done) between two requesters.
//  Round-robin arbitration, operand capture, adder start sequencing, result return and per-op cycle count.
//  Sits between the adder and its clients (e.g. modular-arithmetic or exponentiation controllers).
// PARAMETERS
//  WIDTH    514  operand width; result is WIDTH+1 bits
//  CNT_W    16   width of op_cycles counter (saturates at all-ones)
// PORTS
//  clk           in   1        clock; all state on rising edge
//  reset         in   1        synchronous, active-high reset
//  r0_req        in   1        port 0 request; level, held until r0_ack
//  r0_subtract   in   1        port 0: 1 = a-b (two's complement), 0 = a+b
//  r0_a, r0_b    in   WIDTH    port 0 operands; stable while r0_req=1
//  r0_ack        out  1        1-cycle pulse: port 0 request accepted
//  r0_done       out  1        1-cycle pulse: r0_result valid
//  r0_result     out  WIDTH+1  port 0 result; held until next port-0 completion
//  r1_*          --   --       identical set for port 1 (r1_req ... r1_result)
//  add_start     out  1        1-cycle start pulse to adder
//  add_subtract  out  1        mode to adder; stable from ISSUE until done
//  add_a, add_b  out  WIDTH    registered operands to adder; stable from ISSUE until done
//  add_result    in   WIDTH+1  adder result; valid when add_done=1
//  add_done      in   1        adder completion (pulse or level)
//  busy          out  1        1 whenever state != IDLE
//  op_cycles     out  CNT_W    cycles of last completed op (ISSUE through done-sample, inclusive)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (acks, dones, results, add_*, busy, op_cycles); last_grant=1.
//  FSM: IDLE -> ISSUE -> ARM -> WAIT -> RESP -> IDLE.
//   IDLE: if any req sampled high: pick winner, latch its a/b/subtract into add_a/add_b/add_subtract, record owner.
//   ISSUE (1 cyc): add_start=1, rX_ack=1 for owner; cnt=1.
//   ARM (1 cyc): add_done ignored (masks stale done from previous op); cnt++.
//   WAIT: cnt++ each cycle; on add_done=1 latch add_result into owner's result reg, op_cycles<=cnt.
//   RESP (1 cyc): rX_done=1 for owner; last_grant<=owner.
//  Latency: req seen at edge t -> ack and add_start in cycle t+1; done one cycle after adder done sampled.
//  Arbitration: one req -> it wins. Both -> port != last_grant wins. First contested grant after reset -> port 0.
//  Req still high in the IDLE after RESP = new request (requester must drop req after ack if no further op).
//  Req rising during non-IDLE states waits; never lost, never acked twice per op.
//  Non-owner's result/done untouched by another port's op.
//  add_a/add_b/add_subtract hold their value after op end (no toggling in IDLE).
//  cnt saturates at 2^CNT_W-1; no timeout; hang in WAIT if adder never signals done.
//  Reset mid-op (any state): immediate return to IDLE, reset values; in-flight op discarded, no done; pending reqs re-arbitrated from last_grant=1.
//  Arithmetic is done only by the adder; result passed through unmodified (WIDTH+1 bits incl. carry/borrow).
// TESTING
//  T1 r0 add 1+1 with real adder -> r0_ack once, r0_done once, r0_result=2, r1_done never high.
//  T2 r1 sub 1-1 -> r1_result=0; then the 513-bit add/sub vectors of the adder bench via both ports -> the matching expected results.
//  T3 r0_req and r1_req raised same cycle, held until ack, reraised twice -> grant order r0,r1,r0,r1; each result to its own port.
//  T4 stub adder raising done 3 cycles after ISSUE cycle, plus stale done held high during ARM -> op_cycles=4, stale done ignored.
//  T5 reset pulsed during WAIT -> next cycle all outputs 0, state IDLE, no r*_done; following op completes correctly.
//  T6 r0 holds req continuously while r1 requests -> alternation r0,r1,r0; busy low exactly one cycle between ops.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one multi-precision adder/subtractor between two requesters,
// with operand capture, start sequencing, result return and per-op cycle count.
module adder_arbiter #(
    parameter int WIDTH = 514,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_req,
    input  logic             r0_subtract,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_ack,
    output logic             r0_done,
    output logic [WIDTH:0]   r0_result,
    input  logic             r1_req,
    input  logic             r1_subtract,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_ack,
    output logic             r1_done,
    output logic [WIDTH:0]   r1_result,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done,
    output logic             busy,
    output logic [CNT_W-1:0] op_cycles
);
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d, last_q, last_d, sub_q, sub_d, win;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   res0_q, res0_d, res1_q, res1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;

    always_comb begin
        win     = (r0_req && r1_req) ? !last_q : !r0_req;
        cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: if (r0_req || r1_req) begin
                state_d = ISSUE;
                owner_d = win;
                sub_d   = win ? r1_subtract : r0_subtract;
                a_d     = win ? r1_a : r0_a;
                b_d     = win ? r1_b : r0_b;
            end
            ISSUE: begin
                state_d = ARM;
                cnt_d   = CNT_W'(1);
            end
            // add_done is ignored here so a done left over from the previous op cannot complete this one
            ARM: begin
                state_d = WAIT;
                cnt_d   = cnt_inc;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (add_done) begin
                    state_d = RESP;
                    cyc_d   = cnt_inc;
                    res0_d  = owner_q ? res0_q : add_result;
                    res1_d  = owner_q ? add_result : res1_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign add_start    = state_q == ISSUE;
    assign r0_ack       = add_start && !owner_q;
    assign r1_ack       = add_start && owner_q;
    assign r0_done      = state_q == RESP && !owner_q;
    assign r1_done      = state_q == RESP && owner_q;
    assign busy         = state_q != IDLE;
    assign add_subtract = sub_q;
    assign add_a        = a_q;
    assign add_b        = b_q;
    assign r0_result    = res0_q;
    assign r1_result    = res1_q;
    assign op_cycles    = cyc_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against an arbitration/arithmetic
// reference model, with a behavioural adder of programmable latency and optional stale done.
module tb_adder_arbiter;
    localparam int W  = 514;
    localparam int CW = 16;

    logic           clk = 0, reset = 1;
    logic [1:0]     req = '0;
    logic           s_v [2];
    logic [W-1:0]   a_v [2];
    logic [W-1:0]   b_v [2];
    logic           r0_ack, r0_done, r1_ack, r1_done;
    logic [W:0]     r0_result, r1_result;
    logic           add_start, add_subtract, add_done, busy;
    logic [W-1:0]   add_a, add_b;
    logic [W:0]     add_result, res_q;
    logic [CW-1:0]  op_cycles;

    int tests = 0, fails = 0;
    int lat = 2, lat_q = 2, dc = 0;
    bit stale = 0, pend = 0, last = 1;
    logic [W:0] exp_res [2];

    adder_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(req[0]), .r0_subtract(s_v[0]), .r0_a(a_v[0]), .r0_b(b_v[0]),
        .r0_ack(r0_ack), .r0_done(r0_done), .r0_result(r0_result),
        .r1_req(req[1]), .r1_subtract(s_v[1]), .r1_a(a_v[1]), .r1_b(b_v[1]),
        .r1_ack(r1_ack), .r1_done(r1_done), .r1_result(r1_result),
        .add_start(add_start), .add_subtract(add_subtract), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done), .busy(busy), .op_cycles(op_cycles)
    );

    always #5 clk = ~clk;

    // Adder stand-in: done arrives lat cycles after the ISSUE cycle; a stale done with a bogus result may sit on ARM
    always @(posedge clk) begin
        if (reset) begin
            pend <= 0; add_done <= 0; add_result <= '0; res_q <= '0;
        end else if (add_start) begin
            pend <= 1; dc <= 1; lat_q <= lat;
            add_done <= stale; add_result <= '1;
            res_q <= add_subtract ? {1'b0, add_a} - {1'b0, add_b} : {1'b0, add_a} + {1'b0, add_b};
        end else if (pend) begin
            dc <= dc + 1;
            add_done <= (dc + 1 == lat_q);
            add_result <= (dc + 1 == lat_q) ? res_q : '1;
            if (dc + 1 == lat_q) pend <= 0;
        end else begin
            add_done <= 0;
        end
    end

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v = '0;
        repeat (17) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_acks"}, {r1_ack, r0_ack}, 0);
        chk({tag, "_dones"}, {r1_done, r0_done}, 0);
        chk({tag, "_r0_result"}, r0_result, 0);
        chk({tag, "_r1_result"}, r1_result, 0);
        chk({tag, "_add_ctl"}, {add_start, add_subtract}, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_op_cycles"}, op_cycles, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 0;
        last = 1;
        exp_res[0] = '0;
        exp_res[1] = '0;
    endtask

    task automatic setop(input int p, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        s_v[p] = s; a_v[p] = a; b_v[p] = b;
    endtask

    task automatic wait_ack(output bit got, output int waited);
        got = 0; waited = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            waited++;
            got = r0_ack | r1_ack;
        end
        tests++;
        assert (got) else begin fails++; $error("FAIL ack_timeout observed=none expected=ack"); end
    endtask

    // One arbitrated op: predicts winner and result, drops the winner's req unless held, follows to done
    task automatic serve(input logic [1:0] hold, output int waited);
        bit got; int w, n, extra;
        wait_ack(got, waited);
        if (!got) begin req = '0; return; end
        w = (req == 2'b11) ? int'(!last) : (req[0] ? 0 : 1);
        chk("ack_port", {r1_ack, r0_ack}, w ? 2'b10 : 2'b01);
        chk("busy_issue", {busy, add_start}, 2'b11);
        exp_res[w] = s_v[w] ? {1'b0, a_v[w]} - {1'b0, b_v[w]} : {1'b0, a_v[w]} + {1'b0, b_v[w]};
        if (!hold[w]) req[w] = 0;
        got = 0; n = 0; extra = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            n++;
            extra += int'(r0_ack | r1_ack);
            got = r0_done | r1_done;
        end
        chk("extra_acks", extra, 0);
        chk("done_port", {r1_done, r0_done}, w ? 2'b10 : 2'b01);
        chk("done_latency", n, lat + 1);
        chk("r0_result", r0_result, exp_res[0]);
        chk("r1_result", r1_result, exp_res[1]);
        chk("op_cycles", op_cycles, lat + 1);
        @(negedge clk);
        chk("idle_gap", {busy, r1_done, r0_done}, 0);
        last = w[0];
    endtask

    initial begin
        int wt, nd;
        bit got;
        logic [1:0] pat;
        for (int p = 0; p < 2; p++) setop(p, 0, '0, '0);
        do_reset();

        // T1: r0 add 1+1
        setop(0, 0, 1, 1); req = 2'b01; lat = 2;
        serve(2'b00, wt);
        chk("t1_result", r0_result, 2);

        // T2: r1 sub 1-1, then wide carry/borrow vectors on both ports
        setop(1, 1, 1, 1); req = 2'b10;
        serve(2'b00, wt);
        chk("t2_result", r1_result, 0);
        setop(0, 0, {1'b0, {(W-1){1'b1}}}, 1); req = 2'b01; serve(2'b00, wt);
        setop(1, 1, 0, 1); req = 2'b10; serve(2'b00, wt);
        chk("t2_borrow", r1_result, {(W+1){1'b1}});
        setop(0, 0, '1, '1); req = 2'b01; serve(2'b00, wt);
        setop(1, 1, '1, rnd()); req = 2'b10; serve(2'b00, wt);

        // T3: contested requests after reset, two rounds
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++) setop(p, 1'($urandom), rnd(), rnd());
            req = 2'b11;
            serve(2'b00, wt);
            serve(2'b00, wt);
        end

        // T4: stale done during ARM, done 3 cycles after ISSUE
        setop(0, 0, rnd(), rnd()); req = 2'b01; lat = 3; stale = 1;
        serve(2'b00, wt);
        chk("t4_op_cycles", op_cycles, 4);
        stale = 0;

        // T5: reset during WAIT discards the op
        lat = 6;
        setop(0, 0, rnd(), rnd()); req = 2'b01;
        wait_ack(got, wt);
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_zero("t5");
        last = 1; exp_res[0] = '0; exp_res[1] = '0;
        nd = 0;
        repeat (8) begin @(negedge clk); nd += int'(r0_done | r1_done | busy); end
        chk("t5_no_done", nd, 0);
        setop(1, 1, rnd(), rnd()); req = 2'b10; lat = 2;
        serve(2'b00, wt);

        // T6: r0 held continuously while r1 requests once
        do_reset();
        for (int p = 0; p < 2; p++) setop(p, 0, rnd(), rnd());
        req = 2'b11;
        serve(2'b01, wt);
        serve(2'b01, wt);
        chk("t6_gap1", wt, 1);
        serve(2'b00, wt);
        chk("t6_gap2", wt, 1);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            pat = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++)
                if (pat[p]) setop(p, 1'($urandom), ($urandom_range(0, 7) == 0) ? '1 : rnd(), rnd());
            lat = $urandom_range(2, 7);
            stale = 1'($urandom);
            req = pat;
            for (int k = 0; k < 4 && req != 0; k++) serve(2'b00, wt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
